// File: rtl/pipe_controller.sv
// Pipelined control unit: decodes the custom opcode in ID, carries the control bundle through
// ID/EX, EX/MEM and MEM/WB, resolves branches in EX and raises load-use stall and flush.
module pipe_controller #(
    parameter int unsigned OP_W       = 7,
    parameter int unsigned ALUC_W     = 4,
    parameter bit          EXT_BRANCH = 1'b1,
    parameter int unsigned REG_A_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op_d,
    input  logic [REG_A_W-1:0] rs1_d,
    input  logic [REG_A_W-1:0] rs2_d,
    input  logic [REG_A_W-1:0] rd_e,
    input  logic               zero_e,
    input  logic               lt_e,
    output logic               reg_write_e,
    output logic               reg_write_m,
    output logic               reg_write_w,
    output logic               mem_write_m,
    output logic [1:0]         result_src_w,
    output logic [ALUC_W-1:0]  alu_ctl_e,
    output logic               alu_src_e,
    output logic               jalr_e,
    output logic [2:0]         imm_src_d,
    output logic               pc_src_e,
    output logic               stall_f,
    output logic               stall_d,
    output logic               flush_d,
    output logic               illegal_d
);

    localparam logic [1:0] ResAlu = 2'b00;
    localparam logic [1:0] ResMem = 2'b01;
    localparam logic [1:0] ResPc4 = 2'b10;
    localparam logic [1:0] ResImm = 2'b11;

    typedef enum logic [1:0] {BrEq, BrNe, BrLt, BrGe} br_type_e;

    typedef struct packed {
        logic              reg_write;
        logic [1:0]        result_src;
        logic              mem_write;
        logic [ALUC_W-1:0] alu_ctl;
        logic              alu_src;
        logic              branch;
        br_type_e          br_type;
        logic              jump;
        logic              jalr;
    } ctl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } mem_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } wb_t;

    ctl_t        ctl_d, ex_q;
    mem_t        mem_q;
    wb_t         wb_q;
    logic [31:0] op_val;
    logic        br_cond;
    logic        load_use;

    // Immediate formats: 0 I, 1 S, 2 B, 3 J, 4 U.
    always_comb begin
        ctl_d     = '0;
        imm_src_d = 3'd0;
        illegal_d = 1'b0;
        op_val    = 32'(op_d);
        case (op_val) inside
            [32'd0:32'd4]: begin
                ctl_d.reg_write = 1'b1;
                ctl_d.alu_ctl   = (op_val == 32'd4) ? ALUC_W'(7) : ALUC_W'(op_val);
            end
            [32'd5:32'd9]: begin
                ctl_d.reg_write = 1'b1;
                ctl_d.alu_src   = 1'b1;
                ctl_d.alu_ctl   = (op_val == 32'd9) ? ALUC_W'(7) : ALUC_W'(op_val - 32'd5);
            end
            32'd10: begin
                ctl_d.reg_write  = 1'b1;
                ctl_d.alu_src    = 1'b1;
                ctl_d.result_src = ResMem;
            end
            32'd11: begin
                ctl_d.mem_write = 1'b1;
                ctl_d.alu_src   = 1'b1;
                imm_src_d       = 3'd1;
            end
            32'd12: begin
                ctl_d.reg_write  = 1'b1;
                ctl_d.jump       = 1'b1;
                ctl_d.result_src = ResPc4;
                imm_src_d        = 3'd3;
            end
            [32'd13:32'd16]: begin
                if (EXT_BRANCH || op_val == 32'd13) begin
                    ctl_d.branch  = 1'b1;
                    ctl_d.alu_ctl = ALUC_W'(1);
                    // 13,14,15,16 have low bits 01,10,11,00: minus one gives eq,ne,lt,ge
                    ctl_d.br_type = br_type_e'(op_d[1:0] - 2'd1);
                    imm_src_d     = 3'd2;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            32'd17: begin
                ctl_d.reg_write  = 1'b1;
                ctl_d.jalr       = 1'b1;
                ctl_d.alu_src    = 1'b1;
                ctl_d.result_src = ResPc4;
            end
            32'd18: begin
                ctl_d.reg_write  = 1'b1;
                ctl_d.result_src = ResImm;
                imm_src_d        = 3'd4;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (ex_q.br_type)
            BrEq:    br_cond = zero_e;
            BrNe:    br_cond = !zero_e;
            BrLt:    br_cond = lt_e;
            BrGe:    br_cond = !lt_e;
            default: br_cond = 1'b0;
        endcase
    end

    assign pc_src_e = (ex_q.branch & br_cond) | ex_q.jump | ex_q.jalr;
    assign load_use = (ex_q.result_src == ResMem) && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));
    // A redirect flushes the would-be stalled instruction, so it overrides the stall.
    assign stall_f  = load_use & ~pc_src_e;
    assign stall_d  = load_use & ~pc_src_e;
    assign flush_d  = pc_src_e;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q             <= (stall_d || pc_src_e) ? '0 : ctl_d;
            mem_q.reg_write  <= ex_q.reg_write;
            mem_q.result_src <= ex_q.result_src;
            mem_q.mem_write  <= ex_q.mem_write;
            wb_q.reg_write   <= mem_q.reg_write;
            wb_q.result_src  <= mem_q.result_src;
        end
    end

    assign reg_write_e  = ex_q.reg_write;
    assign alu_ctl_e    = ex_q.alu_ctl;
    assign alu_src_e    = ex_q.alu_src;
    assign jalr_e       = ex_q.jalr;
    assign reg_write_m  = mem_q.reg_write;
    assign mem_write_m  = mem_q.mem_write;
    assign reg_write_w  = wb_q.reg_write;
    assign result_src_w = wb_q.result_src;

endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: tracks which opcode sits in EX/MEM/WB and derives every output
// from the opcode rules; runs an EXT_BRANCH=1 and an EXT_BRANCH=0 instance side by side.
module tb_pipe_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op_d;
    logic [4:0] rs1_d, rs2_d, rd_e;
    logic       zero_e, lt_e;

    logic [1:0] rw_e, rw_m, rw_w, mw_m, jalr_e, alu_src_e, pc_src, stall_f, stall_d, flush, ill;
    logic [1:0] res_w0, res_w1;
    logic [3:0] alu0, alu1;
    logic [2:0] imm0, imm1;

    int passed = 0;
    int total  = 0;
    int ex_op[2]  = '{-1, -1};
    int mem_op[2] = '{-1, -1};
    int wb_op[2]  = '{-1, -1};

    pipe_controller #(.EXT_BRANCH(1'b1)) dut (
        .clk(clk), .rst(rst), .op_d(op_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
        .zero_e(zero_e), .lt_e(lt_e), .reg_write_e(rw_e[0]), .reg_write_m(rw_m[0]),
        .reg_write_w(rw_w[0]), .mem_write_m(mw_m[0]), .result_src_w(res_w0),
        .alu_ctl_e(alu0), .alu_src_e(alu_src_e[0]), .jalr_e(jalr_e[0]), .imm_src_d(imm0),
        .pc_src_e(pc_src[0]), .stall_f(stall_f[0]), .stall_d(stall_d[0]), .flush_d(flush[0]),
        .illegal_d(ill[0])
    );

    pipe_controller #(.EXT_BRANCH(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .op_d(op_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
        .zero_e(zero_e), .lt_e(lt_e), .reg_write_e(rw_e[1]), .reg_write_m(rw_m[1]),
        .reg_write_w(rw_w[1]), .mem_write_m(mw_m[1]), .result_src_w(res_w1),
        .alu_ctl_e(alu1), .alu_src_e(alu_src_e[1]), .jalr_e(jalr_e[1]), .imm_src_d(imm1),
        .pc_src_e(pc_src[1]), .stall_f(stall_f[1]), .stall_d(stall_d[1]), .flush_d(flush[1]),
        .illegal_d(ill[1])
    );

    always #5 clk = ~clk;

    // Opcode rules; -1 stands for a bubble.
    function automatic bit legal(int op, bit ext);
        return op >= 0 && op <= 18 && (ext || op < 14 || op > 16);
    endfunction

    function automatic bit writes(int op, bit ext);
        return legal(op, ext) && op != 11 && !(op >= 13 && op <= 16);
    endfunction

    function automatic logic [1:0] res_src(int op);
        case (op)
            10:      return 2'd1;
            12, 17:  return 2'd2;
            18:      return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] alu_fn(int op);
        int b;
        if (op >= 0 && op <= 9) begin
            b = op % 5;
            return (b == 4) ? 4'd7 : 4'(b);
        end
        if (op >= 13 && op <= 16) return 4'd1;
        return 4'd0;
    endfunction

    function automatic bit uses_imm(int op);
        return (op >= 5 && op <= 11) || op == 17;
    endfunction

    function automatic logic [2:0] imm_fmt(int op, bit ext);
        if (!legal(op, ext)) return 3'd0;
        if (op == 11) return 3'd1;
        if (op >= 13 && op <= 16) return 3'd2;
        if (op == 12) return 3'd3;
        if (op == 18) return 3'd4;
        return 3'd0;
    endfunction

    function automatic bit taken(int op, bit z, bit l);
        case (op)
            12, 17:  return 1'b1;
            13:      return z;
            14:      return !z;
            15:      return l;
            16:      return !l;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit hazard(int ex);
        return res_src(ex) == 2'd1 && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            ex_op[k] = -1; mem_op[k] = -1; wb_op[k] = -1;
        end
    endtask

    task automatic advance(input int k);
        bit ext, pc, lu;
        int cur;
        ext = (k == 0);
        cur = int'(op_d);
        if (!rst) begin
            ex_op[k] = -1; mem_op[k] = -1; wb_op[k] = -1;
            return;
        end
        pc = taken(ex_op[k], zero_e, lt_e);
        lu = hazard(ex_op[k]);
        wb_op[k]  = mem_op[k];
        mem_op[k] = ex_op[k];
        ex_op[k]  = (lu || pc || !legal(cur, ext)) ? -1 : cur;
    endtask

    task automatic step(input int op, input int r1, input int r2, input int rd,
                        input bit z, input bit l, input bit rv);
        @(posedge clk);
        for (int k = 0; k < 2; k++) advance(k);
        #1;
        op_d = 7'(op); rs1_d = 5'(r1); rs2_d = 5'(r2); rd_e = 5'(rd);
        zero_e = z; lt_e = l; rst = rv;
        if (!rv) clear_model();
    endtask

    task automatic op_only(input int op);
        step(op, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin : compare
        bit ext, pc, st;
        logic [3:0] alu_a;
        logic [2:0] imm_a;
        logic [1:0] res_a;
        for (int k = 0; k < 2; k++) begin
            ext   = (k == 0);
            alu_a = (k == 0) ? alu0 : alu1;
            imm_a = (k == 0) ? imm0 : imm1;
            res_a = (k == 0) ? res_w0 : res_w1;
            pc    = taken(ex_op[k], zero_e, lt_e);
            st    = hazard(ex_op[k]) && !pc;
            check("pipe", {rw_e[k], rw_m[k], rw_w[k], mw_m[k], res_a},
                  {writes(ex_op[k], ext), writes(mem_op[k], ext), writes(wb_op[k], ext),
                   mem_op[k] == 11, res_src(wb_op[k])});
            check("ex", {alu_a, alu_src_e[k], jalr_e[k]},
                  {alu_fn(ex_op[k]), uses_imm(ex_op[k]), ex_op[k] == 17});
            check("hazard", {pc_src[k], stall_f[k], stall_d[k], flush[k]}, {pc, st, st, pc});
            check("id", {imm_a, ill[k]}, {imm_fmt(int'(op_d), ext), !legal(int'(op_d), ext)});
        end
    end

    bit exp_taken[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        op_d = 7'd100; rs1_d = '0; rs2_d = '0; rd_e = '0; zero_e = 1'b0; lt_e = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_illegal", ill[0], 1);
        check("reset_outputs", {rw_e[0], rw_m[0], rw_w[0], pc_src[0], stall_f[0], flush[0]}, 0);

        // R-type flow through all stages
        op_only(2);
        op_only(100); @(negedge clk);
        check("r_ex", {alu0, rw_e[0]}, {4'd2, 1'b1});
        op_only(100); @(negedge clk);
        check("r_mem", {rw_m[0], rw_e[0]}, 2'b10);
        op_only(100); @(negedge clk);
        check("r_wb", {rw_w[0], res_w0}, 3'b100);

        // Reset asserted between edges
        op_only(0); op_only(0); op_only(0); op_only(100);
        @(negedge clk);
        check("pre_reset_writes", {rw_e[0], rw_m[0], rw_w[0]}, 3'b111);
        #2 rst = 1'b0;
        clear_model();
        #1 check("async_reset", {rw_e[0], rw_m[0], rw_w[0], pc_src[0]}, 0);
        op_only(100);

        // Load-use with rd=5, then with rd=0
        op_only(10);
        step(0, 5, 0, 5, 1'b0, 1'b0, 1'b1); @(negedge clk);
        check("lu_stall", {stall_f[0], stall_d[0], flush[0]}, 3'b110);
        step(0, 5, 0, 7, 1'b0, 1'b0, 1'b1); @(negedge clk);
        check("lu_bubble", {stall_f[0], rw_e[0]}, 2'b00);
        op_only(100); @(negedge clk);
        check("lu_resume", {rw_e[0], alu0}, {1'b1, 4'd0});
        op_only(10);
        step(0, 0, 0, 0, 1'b0, 1'b0, 1'b1); @(negedge clk);
        check("lu_rd0", stall_f[0], 0);

        // Branch types with zero=1, lt=0
        for (int i = 0; i < 4; i++) begin
            op_only(13 + i);
            step(2, 0, 0, 0, 1'b1, 1'b0, 1'b1); @(negedge clk);
            check("br_taken", {pc_src[0], flush[0]}, {exp_taken[i], exp_taken[i]});
            op_only(100); @(negedge clk);
            check("br_next_ex", {alu0, rw_e[0]},
                  {exp_taken[i] ? 4'd0 : 4'd2, !exp_taken[i]});
        end

        // Redirect coincident with a matching rd/rs pair
        op_only(13);
        step(0, 5, 0, 5, 1'b1, 1'b0, 1'b1); @(negedge clk);
        check("priority", {pc_src[0], stall_f[0], stall_d[0], flush[0]}, 4'b1001);

        // Illegal opcodes and EXT_BRANCH=0
        op_only(100); @(negedge clk);
        check("illegal_100", ill, 2'b11);
        step(14, 0, 0, 0, 1'b1, 1'b0, 1'b1); @(negedge clk);
        check("illegal_14", {ill, rw_e[0], pc_src[0]}, 4'b1000);
        step(127, 0, 0, 0, 1'b1, 1'b0, 1'b1); @(negedge clk);
        check("illegal_ex_nb", {rw_e[1], pc_src[1], ill[0]}, 3'b001);

        for (int n = 0; n < 3000; n++) begin
            int op;
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127))
                                              : int'($urandom_range(0, 19));
            step(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 199) != 0);
        end
        op_only(100);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_controller.md
Name: pipe_controller

Overview:
Parametrised, pipelined successor to the single-cycle decode controller for the RISC-V pipeline.
- Decodes the custom 7-bit opcode in ID into a control bundle.
- Carries the bundle through ID/EX, EX/MEM and MEM/WB registers.
- Resolves branches and jumps in EX using extended branch types.
- Generates load-use stall, flush and bubble controls for the datapath, replacing ad-hoc hazard glue.

Parameters:
OP_W, 7, opcode width; opcodes at or above 2^OP_W are unreachable.
ALUC_W, 4, ALU control field width.
EXT_BRANCH, 1, 1 = ops 14..16 are bne/blt/bge; 0 = those ops are illegal.
REG_A_W, 5, register-address width used for hazard compare.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
op_d  in  OP_W  opcode of the instruction in ID
rs1_d, rs2_d  in  REG_A_W  ID source registers
rd_e  in  REG_A_W  EX destination register
zero_e, lt_e  in  1  ALU equal and signed-less-than flags, EX stage
reg_write_e/m/w  out  1  per-stage register write enable
mem_write_m  out  1  store enable, MEM stage
result_src_w  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm
alu_ctl_e  out  ALUC_W  ALU operation
alu_src_e, jalr_e  out  1  immediate operand select; jalr target select
imm_src_d  out  3  immediate format, combinational from op_d
pc_src_e  out  1  redirect PC
stall_f, stall_d  out  1  hold PC and IF/ID
flush_d  out  1  clear IF/ID
illegal_d  out  1  undecodable opcode in ID

Behaviour:
- Decode, combinational, in ID:
  - ops 0..4: R-type; alu_ctl 0, 1, 2, 3, 7.
  - ops 5..9: I-type ALU; alu_src=1.
  - op 10: load, result 01.
  - op 11: store, mem_write.
  - op 12: jal, result 10.
  - op 13: beq; ops 14..16: bne/blt/bge.
  - op 17: jalr.
  - op 18: lui, result 11.
  - Any other op: all-zero bundle and illegal_d=1.
- Bubble means an all-zero bundle: no write, no branch, no jump.
- Pipeline registers:
  - ID/EX, EX/MEM and MEM/WB update every clk.
  - EX/MEM and MEM/WB are never stalled.
  - ID/EX loads a bubble when stall_d=1 or pc_src_e=1.
- Branch resolution in EX:
  - Condition by type: beq=zero_e, bne=!zero_e, blt=lt_e, bge=!lt_e.
  - pc_src_e = (branch_e & cond) | jump_e | jalr_e. Combinational, 0-cycle latency from EX flags.
- Flush: flush_d = pc_src_e.
  - A taken branch costs two bubbles: IF/ID is cleared, and ID/EX is bubbled at the same edge.
- Load-use hazard:
  - Detected when result_src_e==01, rd_e!=0, and rd_e equals rs1_d or rs2_d.
  - On detection: stall_f = stall_d = 1 and ID/EX loads a bubble. Exactly one cycle, since the load then leaves EX.
- Simultaneous events: pc_src_e wins. stall_f and stall_d are forced to 0 because the stalled instruction is flushed anyway.
- Reset:
  - Asserting rst low clears all three pipeline registers to bubble immediately (asynchronous), including mid-operation.
  - While reset is held: pc_src_e, stall and flush outputs are 0. illegal_d and imm_src_d still follow op_d.
- Illegal op: travels as a bubble. No write and no redirect are performed.
- EXT_BRANCH=0: ops 14..16 decode as illegal.

Test Plan:
- Reset mid-stream: drive op_d=0 for 3 cycles, pull rst low between edges -> reg_write_e/m/w all 0 immediately; pc_src_e=0.
- R-type flow: op_d=2 at cycle 0 -> alu_ctl_e=2 and reg_write_e=1 at cycle 1; reg_write_m=1 at cycle 2; reg_write_w=1 and result_src_w=00 at cycle 3.
- Load-use: load (op 10, rd=5) then op 0 with rs1_d=5 -> stall_f=stall_d=1 for exactly one cycle and a bubble in EX. Repeat with rd=0 -> no stall.
- Branch types: ops 13..16 with (zero_e, lt_e) = (1,0) -> pc_src_e = 1, 0, 0, 1. Taken branch -> flush_d=1 and next alu_ctl_e from a bubble.
- Priority: load-use condition coincident with taken branch in EX -> pc_src_e=1, stall_f=0, flush_d=1.
- Illegal: op_d=100 -> illegal_d=1 and no write in any stage. With EXT_BRANCH=0, op_d=14 -> illegal_d=1.
